morse_keyer_ctrl: RTL and testbench

- Front-end sequencer for the Morse-to-ASCII decoder.
- Samples a raw telegraph key and times each press and gap in dot units from an external tick.
- Classifies presses as dot (2'b10) or dash (2'b11) and packs them MSB-first into the 10-bit code word the decoder consumes.
- At a letter gap it hands the word over with a valid/ready handshake; at a word gap it issues the space code 10'b0.

---
 rtl/morse_keyer_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer_ctrl.sv
// morse_keyer_ctrl: front-end sequencer for the Morse-to-ASCII decoder.
// Times key presses and gaps in dot units from an external tick and packs
// dot/dash symbols MSB-first into a 10-bit word. It hands over one word per
// letter and one space word per word gap through a valid/ready handshake.
module morse_keyer_ctrl #(
    parameter int DASH_UNITS = 2,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_in,
    output logic [9:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [2:0] sym_count,
    output logic       overflow,
    output logic       drop,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        EMIT,
        WORD_WAIT,
        WORD_EMIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] LGAP_C  = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WGAP_C  = CNT_W'(WORD_GAP);
    localparam logic [2:0]       MAX_SYM = 3'd5;

    localparam logic [1:0] SYM_DOT  = 2'b10;
    localparam logic [1:0] SYM_DASH = 2'b11;

    state_t           state;
    logic             key_m;
    logic             key_s;
    logic             key_d;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [9:0]       code_reg;
    logic [1:0]       sym;

    // Two-flop synchroniser on the raw key plus one delay flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
            key_d <= 1'b0;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
            key_d <= key_s;
        end
    end

    assign rise = key_s & ~key_d;
    assign fall = ~key_s & key_d;

    // The symbol is classified from the press length held at the moment of release
    assign sym = (press_cnt < DASH_C) ? SYM_DOT : SYM_DASH;

    // Press and gap timers; an edge clear beats a coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (rise)
                press_cnt <= '0;
            else if (tick && key_s && press_cnt != CNT_MAX)
                press_cnt <= press_cnt + 1'b1;

            if (fall)
                gap_cnt <= '0;
            else if (tick && !key_s && gap_cnt != CNT_MAX)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Sequencer: symbol assembly, letter/word hand-off and drop reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code_reg   <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            sym_count  <= '0;
            overflow   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise)
                        state <= MARK;
                end

                MARK: begin
                    if (fall) begin
                        // A sixth symbol cannot be encoded; flag it and leave the word alone
                        if (sym_count == MAX_SYM) begin
                            overflow <= 1'b1;
                        end else begin
                            for (int i = 0; i < 5; i++)
                                if (sym_count == 3'(i))
                                    code_reg[9-2*i -: 2] <= sym;
                            sym_count <= sym_count + 3'd1;
                        end
                        state <= SPACE;
                    end
                end

                SPACE: begin
                    if (rise) begin
                        state <= MARK;
                    end else if (gap_cnt >= LGAP_C) begin
                        if (overflow) begin
                            // Corrupt letter is discarded silently; no word space follows it
                            code_reg  <= '0;
                            sym_count <= '0;
                            overflow  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            code_out   <= code_reg;
                            code_valid <= 1'b1;
                            state      <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    // A release while the letter is still pending has nowhere to go
                    if (fall)
                        drop <= 1'b1;
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        code_out   <= '0;
                        code_reg   <= '0;
                        sym_count  <= '0;
                        overflow   <= 1'b0;
                        state      <= key_s ? MARK : WORD_WAIT;
                    end
                end

                WORD_WAIT: begin
                    if (rise) begin
                        state <= MARK;
                    end else if (gap_cnt >= WGAP_C) begin
                        code_out   <= '0;
                        code_valid <= 1'b1;
                        state      <= WORD_EMIT;
                    end
                end

                WORD_EMIT: begin
                    if (fall)
                        drop <= 1'b1;
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        code_out   <= '0;
                        state      <= key_s ? MARK : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Bench for morse_keyer_ctrl: directed scenarios plus randomized letters
// checked against a symbol-level model of what the decoder should receive.
module tb_morse_keyer_ctrl;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       tick       = 1'b0;
    logic       key_in     = 1'b0;
    logic       code_ready = 1'b0;
    logic [9:0] code_out;
    logic       code_valid;
    logic [2:0] sym_count;
    logic       overflow;
    logic       drop;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int tcnt = 0;
    int rdy_mode = 1;       // 0: random with bounded stall, 1: held low, 2: held high
    int wait_cnt = 0;
    int drop_cycles = 0;
    bit hold = 1'b0;
    logic [9:0] hold_code = '0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    morse_keyer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .key_in     (key_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .sym_count  (sym_count),
        .overflow   (overflow),
        .drop       (drop),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] q_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 10'h3ff;
    endfunction

    // One clock: sample at negedge, check held handshake, log transfers, drive tick/ready
    task automatic cyc();
        logic r;
        r = rst;
        @(negedge clk);
        if (hold && !r) begin
            chk("hold_valid", code_valid, 1);
            chk("hold_code", code_out, hold_code);
        end
        if (drop) drop_cycles++;
        tcnt++;
        tick = (tcnt % 4 == 0);
        case (rdy_mode)
            1:       code_ready = 1'b0;
            2:       code_ready = 1'b1;
            default: code_ready = (wait_cnt >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        if (code_valid && !code_ready) wait_cnt++;
        else wait_cnt = 0;
        if (code_valid && code_ready) got_q.push_back(code_out);
        hold = code_valid && !code_ready;
        hold_code = code_out;
    endtask

    // Key changes land just after a tick so each held tick-unit counts exactly once
    task automatic align();
        while (tcnt % 4 != 1) cyc();
    endtask

    task automatic key_for(input logic lvl, input int n);
        key_in = lvl;
        repeat (4 * n) cyc();
    endtask

    task automatic wait_valid(input string tag, input int max);
        int i;
        i = 0;
        while (!code_valid && i < max) begin
            cyc();
            i++;
        end
        chk(tag, code_valid, 1);
    endtask

    task automatic wait_q(input string tag, input int n, input int max);
        int i;
        i = 0;
        while (got_q.size() < n && i < max) begin
            cyc();
            i++;
        end
        chk(tag, got_q.size(), n);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int ns;
        int gap;
        int d;
        int m;
        logic [9:0] w;

        // Reset state
        repeat (3) cyc();
        chk("rst_code", code_out, 0);
        chk("rst_valid", code_valid, 0);
        chk("rst_sym", sym_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Dot then dash, stalled handshake, then the word space
        rdy_mode = 1;
        align();
        key_for(1, 1);
        key_for(0, 1);
        key_for(1, 3);
        key_in = 1'b0;
        wait_valid("a_valid", 60);
        chk("a_code", code_out, 10'b10_11_00_00_00);
        chk("a_sym", sym_count, 2);
        chk("a_busy", busy, 1);
        repeat (10) cyc();
        chk("a_still", code_valid, 1);
        rdy_mode = 2;
        cyc();
        cyc();
        chk("a_clr", code_valid, 0);
        chk("a_sym0", sym_count, 0);
        chk("a_xfer", q_at(0), 10'b10_11_00_00_00);
        wait_q("a_space_n", 2, 200);
        chk("a_space", q_at(1), 10'b0);
        repeat (80) cyc();
        chk("a_no3rd", got_q.size(), 2);
        chk("a_idle", busy, 0);

        // Six dots overflow the letter and are discarded
        got_q.delete();
        align();
        for (int i = 0; i < 5; i++) begin
            key_for(1, 1);
            key_for(0, 1);
        end
        key_for(1, 1);
        key_for(0, 2);
        chk("o_ovf", overflow, 1);
        chk("o_sym", sym_count, 5);
        chk("o_novalid", code_valid, 0);
        key_for(0, 10);
        chk("o_ovf0", overflow, 0);
        chk("o_sym0", sym_count, 0);
        chk("o_idle", busy, 0);
        chk("o_noxfer", got_q.size(), 0);

        // Press and release while the letter waits: one-cycle drop, word intact
        rdy_mode = 1;
        drop_cycles = 0;
        align();
        key_for(1, 3);
        key_in = 1'b0;
        wait_valid("d_valid", 60);
        chk("d_code", code_out, 10'b11_00_00_00_00);
        align();
        key_for(1, 1);
        key_for(0, 2);
        chk("d_pulse", drop_cycles, 1);
        chk("d_code2", code_out, 10'b11_00_00_00_00);
        chk("d_valid2", code_valid, 1);
        chk("d_sym", sym_count, 1);

        // Reset in the middle of the handshake
        pulse_rst();
        chk("r_valid", code_valid, 0);
        chk("r_code", code_out, 0);
        chk("r_sym", sym_count, 0);
        chk("r_ovf", overflow, 0);
        chk("r_drop", drop, 0);
        chk("r_busy", busy, 0);
        got_q.delete();
        rdy_mode = 0;
        align();
        key_for(1, 3);
        key_for(0, 4);
        wait_q("r_n", 1, 100);
        chk("r_word", q_at(0), 10'b11_00_00_00_00);

        // Random letters against the symbol-level model
        pulse_rst();
        got_q.delete();
        exp_q.delete();
        drop_cycles = 0;
        rdy_mode = 0;
        align();
        for (int l = 0; l < 14; l++) begin
            ns  = $urandom_range(1, 6);
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(7, 9) : $urandom_range(3, 6);
            if (l == 13) gap = 10;
            w = '0;
            for (int s = 0; s < ns; s++) begin
                d = $urandom_range(1, 4);
                if (s < 5) w[9-2*s -: 2] = (d >= 2) ? 2'b11 : 2'b10;
                key_for(1, d);
                if (s != ns - 1) key_for(0, $urandom_range(1, 2));
            end
            key_for(0, gap);
            if (ns <= 5) begin
                exp_q.push_back(w);
                if (gap >= 7) exp_q.push_back(10'b0);
            end
        end
        repeat (40) cyc();
        chk("rnd_count", got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk("rnd_word", got_q[i], exp_q[i]);
        chk("rnd_nodrop", drop_cycles, 0);
        chk("rnd_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
